// File: rtl/sequenciador_de_senha_if.sv
// ---------------------------------------------------------------------------
// sequenciador_de_senha_if
// Bundles the key-event input, the consumer acknowledge and the code
// presentation outputs of the password sequencer.
//   tecla_value  [3:0]          key code from the keypad decoder
//   tecla_valid                 one key event per high cycle
//   senha_ack                   consumer acknowledge of the presented code
//   senha_out    [4*MAX_DIGITS] packed BCD code, newest digit in [3:0]
//   senha_len    [LEN_W]        number of valid digits in senha_out
//   senha_valid                 code presented, held until acknowledged
//   erro                        one-cycle pulse on a rejected confirm
//   timeout                     one-cycle pulse when an entry times out
// master: key source / code consumer side.  slave: the sequencer.
// ---------------------------------------------------------------------------
interface sequenciador_de_senha_if #(
  parameter int MAX_DIGITS = 4
);
  localparam int LEN_W = $clog2(MAX_DIGITS + 1);

  logic [3:0]              tecla_value;
  logic                    tecla_valid;
  logic                    senha_ack;
  logic [4*MAX_DIGITS-1:0] senha_out;
  logic [LEN_W-1:0]        senha_len;
  logic                    senha_valid;
  logic                    erro;
  logic                    timeout;

  modport master (
    output tecla_value, tecla_valid, senha_ack,
    input  senha_out, senha_len, senha_valid, erro, timeout
  );

  modport slave (
    input  tecla_value, tecla_valid, senha_ack,
    output senha_out, senha_len, senha_valid, erro, timeout
  );
endinterface

// File: rtl/sequenciador_de_senha.sv
// ---------------------------------------------------------------------------
// sequenciador_de_senha
// Assembles key events from the keypad decoder into a multi-digit BCD code
// with backspace, clear, confirm and inactivity timeout, then presents the
// finished code with a valid/ack handshake.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   sif  : slave side of sequenciador_de_senha_if (keys in, code out)
// All outputs are registered; a key sampled at one edge is visible right
// after that edge.
// ---------------------------------------------------------------------------
module sequenciador_de_senha #(
  parameter int MAX_DIGITS = 4,
  parameter int MIN_DIGITS = 4,
  parameter int TIMEOUT_P  = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  sequenciador_de_senha_if.slave   sif
);

  localparam int BW = 4 * MAX_DIGITS;
  localparam int LW = $clog2(MAX_DIGITS + 1);
  localparam int CW = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;

  localparam logic [3:0]    K_BACK  = 4'hB;
  localparam logic [3:0]    K_CLEAR = 4'hF;
  localparam logic [3:0]    K_CONF  = 4'hE;
  localparam logic [BW-1:0] ALL_F   = {MAX_DIGITS{4'hF}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [BW-1:0]   buf_r, buf_s;
  logic [LW-1:0]   len_r, len_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            valid_r, valid_s;
  logic            erro_r, erro_s;
  logic            timeout_r, timeout_s;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'h9);
  endfunction

  // Next-state, buffer, idle-counter and pulse computation
  always_comb begin
    state_s   = state_r;
    buf_s     = buf_r;
    len_s     = len_r;
    cnt_s     = cnt_r;
    valid_s   = valid_r;
    erro_s    = 1'b0;
    timeout_s = 1'b0;

    case (state_r)
      IDLE: begin
        cnt_s   = '0;
        valid_s = 1'b0;
        if (sif.tecla_valid) begin
          if (is_digit(sif.tecla_value)) begin
            buf_s   = {buf_r[BW-5:0], sif.tecla_value};
            len_s   = LW'(1);
            state_s = ENTRY;
          end else if (sif.tecla_value == K_CONF) begin
            erro_s = 1'b1;
          end else begin
            // backspace, clear and ignored keys leave an empty buffer alone
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end

      ENTRY: begin
        if (sif.tecla_valid) begin
          // any key, even an ignored one, restarts the inactivity window
          cnt_s = '0;
          if (is_digit(sif.tecla_value)) begin
            if (len_r < LW'(MAX_DIGITS)) begin
              buf_s = {buf_r[BW-5:0], sif.tecla_value};
              len_s = len_r + LW'(1);
            end else begin
              // buffer full: extra digits are dropped
              len_s = len_r;
            end
          end else if (sif.tecla_value == K_BACK) begin
            buf_s = {4'hF, buf_r[BW-1:4]};
            len_s = len_r - LW'(1);
            if (len_r == LW'(1)) begin
              state_s = IDLE;
            end else begin
              state_s = ENTRY;
            end
          end else if (sif.tecla_value == K_CLEAR) begin
            buf_s   = ALL_F;
            len_s   = '0;
            state_s = IDLE;
          end else if (sif.tecla_value == K_CONF) begin
            if (len_r >= LW'(MIN_DIGITS)) begin
              valid_s = 1'b1;
              state_s = HOLD;
            end else begin
              erro_s  = 1'b1;
              buf_s   = ALL_F;
              len_s   = '0;
              state_s = IDLE;
            end
          end else begin
            state_s = ENTRY;
          end
        end else if (cnt_r == CW'(TIMEOUT_P - 1)) begin
          timeout_s = 1'b1;
          buf_s     = ALL_F;
          len_s     = '0;
          cnt_s     = '0;
          state_s   = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end

      HOLD: begin
        // code frozen, keys ignored, counter parked at zero
        cnt_s   = '0;
        valid_s = 1'b1;
        if (sif.senha_ack) begin
          valid_s = 1'b0;
          buf_s   = ALL_F;
          len_s   = '0;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end

      default: begin
        state_s = IDLE;
        buf_s   = ALL_F;
        len_s   = '0;
        cnt_s   = '0;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      buf_r     <= ALL_F;
      len_r     <= '0;
      cnt_r     <= '0;
      valid_r   <= 1'b0;
      erro_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      buf_r     <= buf_s;
      len_r     <= len_s;
      cnt_r     <= cnt_s;
      valid_r   <= valid_s;
      erro_r    <= erro_s;
      timeout_r <= timeout_s;
    end
  end

  assign sif.senha_out   = buf_r;
  assign sif.senha_len   = len_r;
  assign sif.senha_valid = valid_r;
  assign sif.erro        = erro_r;
  assign sif.timeout     = timeout_r;

endmodule
